tg_packet_checker: RTL and testbench

// - Packet sink directly downstream of the traffic generator output port (o_flit/o_transmit/i_send).
// - Grants the generator's transmit request and receives its HEAD, BODY_COUNT x BODY, TAIL flit stream.
// - Checks flit ordering and head address, and computes latency from the 16-bit tail timestamp.
// - Keeps saturating statistics for the testbench and for debug readout.

---
 rtl/router_pkg.sv | 35 +++
 rtl/sat_counter.sv | 48 ++++
 rtl/tg_packet_checker.sv | 215 +++++++++++++++++++++
 tb/tb_tg_packet_checker.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: flit format shared by the traffic generator and the packet checker.
//   flit[FLIT_SIZE-1]   valid
//   flit[33:32]         FLIT_TYPE_t
//   flit[31:24]         head xaddr
//   flit[23:16]         head yaddr
//   flit[15:0]          tail timestamp (reserved field)
package router_pkg;

  localparam int FLIT_SIZE = 35;

  typedef enum logic [1:0] {
    NONE_FLIT = 2'd0,
    HEAD_FLIT = 2'd1,
    BODY_FLIT = 2'd2,
    TAIL_FLIT = 2'd3
  } FLIT_TYPE_t;

  typedef struct packed {
    logic [FLIT_SIZE-1:0] flit;
  } FLIT_t;

  // Bit indices into the checker error flags.
  localparam int CHK_ERR_SEQ     = 0;
  localparam int CHK_ERR_ADDR    = 1;
  localparam int CHK_ERR_STRAY   = 2;
  localparam int CHK_ERR_TIMEOUT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RECV  = 2'd2,
    CHECK = 2'd3
  } CHK_STATE_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, reset  clock, asynchronous active-high reset
//   i_clr       synchronous clear, wins over any increment
//   i_inc       add 1
//   i_add2      add 2 (wins over i_inc)
//   o_count     current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_add2,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH:0] One = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] Two = (WIDTH+1)'(2);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_sum;

  // One extra bit catches the carry out so overflow clamps instead of wrapping.
  always_comb begin
    w_sum = {1'b0, r_count};
    if (i_add2) begin
      w_sum = w_sum + Two;
    end else if (i_inc) begin
      w_sum = w_sum + One;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (w_sum[WIDTH]) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[WIDTH-1:0];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tg_packet_checker.sv
// tg_packet_checker: packet sink for the traffic generator output port.
// Grants a transmit request, receives HEAD, BODY_COUNT x BODY, TAIL, checks ordering and head
// address, measures latency from the tail timestamp and keeps saturating statistics.
//   clk, reset       clock, asynchronous active-high reset
//   i_enable         allow new grants (a packet in flight always completes)
//   i_clear          synchronous clear of statistics and sticky flags
//   i_transmit       generator request
//   o_send           one-cycle grant pulse
//   i_flit           generator flit, valid in the MSB
//   o_pkt_done       one-cycle pulse per finished packet
//   o_pkt_count      good packets (saturating)
//   o_err_count      bad packets plus stray flits (saturating)
//   o_err_flags      sticky {TIMEOUT, STRAY, ADDR, SEQ}
//   o_last_latency   latency of the last good packet
//   o_max_latency    maximum latency over good packets
module tg_packet_checker
  import router_pkg::*;
#(
  parameter int unsigned BODY_COUNT = 2,
  parameter logic [7:0]  EXP_X      = 8'd1,
  parameter logic [7:0]  EXP_Y      = 8'd0,
  parameter bit          CHECK_ADDR = 1'b1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_clear,
  input  logic        i_transmit,
  output logic        o_send,
  input  FLIT_t       i_flit,
  output logic        o_pkt_done,
  output logic [31:0] o_pkt_count,
  output logic [15:0] o_err_count,
  output logic [3:0]  o_err_flags,
  output logic [15:0] o_last_latency,
  output logic [15:0] o_max_latency
);

  localparam int unsigned      BodyW   = $clog2(BODY_COUNT) + 1;
  localparam int unsigned      IdleW   = $clog2(TIMEOUT + 1);
  localparam logic [BodyW-1:0] BodyNum = BodyW'(BODY_COUNT);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  CHK_STATE_t       r_state;
  logic             r_send;
  logic             r_pkt_done;
  logic             r_got_head;
  logic [BodyW-1:0] r_body;
  logic [3:0]       r_pkt_err;
  logic [15:0]      r_lat;
  logic [15:0]      r_cnt;
  logic [3:0]       r_err_flags;
  logic [15:0]      r_last_lat;
  logic [15:0]      r_max_lat;

  logic             w_valid;
  FLIT_TYPE_t       w_type;
  FLIT_TYPE_t       w_exp_type;
  logic [7:0]       w_xaddr;
  logic [7:0]       w_yaddr;
  logic [15:0]      w_stamp;
  logic             w_in_recv;
  logic             w_stray;
  logic             w_check_bad;
  logic             w_check_good;
  logic             w_timeout;
  logic [IdleW-1:0] w_idle_cnt;
  logic [3:0]       w_flag_set;

  assign w_valid   = i_flit.flit[FLIT_SIZE-1];
  assign w_type    = FLIT_TYPE_t'(i_flit.flit[FLIT_SIZE-2 -: 2]);
  assign w_xaddr   = i_flit.flit[31:24];
  assign w_yaddr   = i_flit.flit[23:16];
  assign w_stamp   = i_flit.flit[15:0];

  assign w_in_recv    = (r_state == RECV);
  assign w_stray      = w_valid && !w_in_recv;
  assign w_check_bad  = (r_state == CHECK) && (r_pkt_err != 4'b0000);
  assign w_check_good = (r_state == CHECK) && (r_pkt_err == 4'b0000);
  assign w_timeout    = w_in_recv && (w_idle_cnt >= IdleMax);

  always_comb begin
    if (!r_got_head) begin
      w_exp_type = HEAD_FLIT;
    end else if (r_body < BodyNum) begin
      w_exp_type = BODY_FLIT;
    end else begin
      w_exp_type = TAIL_FLIT;
    end
  end

  always_comb begin
    w_flag_set                = w_check_bad ? r_pkt_err : 4'b0000;
    w_flag_set[CHK_ERR_STRAY] = w_flag_set[CHK_ERR_STRAY] | w_stray;
  end

  // Packet sequencing FSM with registered grant and done pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_send     <= 1'b0;
      r_pkt_done <= 1'b0;
      r_got_head <= 1'b0;
      r_body     <= '0;
      r_pkt_err  <= 4'b0000;
      r_lat      <= 16'd0;
      r_cnt      <= 16'd0;
    end else begin
      r_cnt      <= r_cnt + 16'd1;
      r_send     <= 1'b0;
      r_pkt_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_enable && i_transmit) begin
            r_state    <= GRANT;
            r_send     <= 1'b1;
            r_got_head <= 1'b0;
            r_body     <= '0;
            r_pkt_err  <= 4'b0000;
          end
        end
        GRANT: r_state <= RECV;
        RECV: begin
          if (w_timeout) begin
            r_pkt_err[CHK_ERR_TIMEOUT] <= 1'b1;
            r_state                    <= CHECK;
            r_pkt_done                 <= 1'b1;
          end else if (w_valid) begin
            if (w_type != w_exp_type) begin
              r_pkt_err[CHK_ERR_SEQ] <= 1'b1;
              r_state                <= CHECK;
              r_pkt_done             <= 1'b1;
            end else begin
              unique case (w_type)
                HEAD_FLIT: begin
                  r_got_head <= 1'b1;
                  if (CHECK_ADDR && ((w_xaddr != EXP_X) || (w_yaddr != EXP_Y))) begin
                    r_pkt_err[CHK_ERR_ADDR] <= 1'b1;
                  end
                end
                BODY_FLIT: r_body <= r_body + BodyW'(1);
                TAIL_FLIT: begin
                  // Modulo-2^16 difference stays correct across counter wrap.
                  r_lat      <= r_cnt - w_stamp;
                  r_state    <= CHECK;
                  r_pkt_done <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        CHECK:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky flags and latency statistics; i_clear beats any same-cycle update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_flags <= 4'b0000;
      r_last_lat  <= 16'd0;
      r_max_lat   <= 16'd0;
    end else if (i_clear) begin
      r_err_flags <= 4'b0000;
      r_last_lat  <= 16'd0;
      r_max_lat   <= 16'd0;
    end else begin
      r_err_flags <= r_err_flags | w_flag_set;
      if (w_check_good) begin
        r_last_lat <= r_lat;
        if (r_lat > r_max_lat) begin
          r_max_lat <= r_lat;
        end
      end
    end
  end

  sat_counter #(.WIDTH(32)) u_pkt_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (i_clear),
    .i_inc   (w_check_good),
    .i_add2  (1'b0),
    .o_count (o_pkt_count)
  );

  // A stray flit landing on a bad packet's CHECK cycle costs two errors at once.
  sat_counter #(.WIDTH(16)) u_err_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (i_clear),
    .i_inc   (w_stray ^ w_check_bad),
    .i_add2  (w_stray & w_check_bad),
    .o_count (o_err_count)
  );

  sat_counter #(.WIDTH(IdleW)) u_idle_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (!w_in_recv || w_valid),
    .i_inc   (w_in_recv && !w_valid),
    .i_add2  (1'b0),
    .o_count (w_idle_cnt)
  );

  assign o_send         = r_send;
  assign o_pkt_done     = r_pkt_done;
  assign o_err_flags    = r_err_flags;
  assign o_last_latency = r_last_lat;
  assign o_max_latency  = r_max_lat;

endmodule

// File: tb/tb_tg_packet_checker.sv
// Bench for tg_packet_checker: directed scenarios plus randomized packets, checked against a
// packet-level statistics model (good/bad/stray outcomes, latency as timestamp difference).
module tb_tg_packet_checker;
  import router_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_enable = 1'b1;
  logic        i_clear = 1'b0;
  logic        i_transmit = 1'b0;
  FLIT_t       i_flit = '0;
  logic        o_send, o_pkt_done;
  logic [31:0] o_pkt_count;
  logic [15:0] o_err_count, o_last_latency, o_max_latency;
  logic [3:0]  o_err_flags;

  tg_packet_checker dut (
    .clk            (clk),
    .reset          (reset),
    .i_enable       (i_enable),
    .i_clear        (i_clear),
    .i_transmit     (i_transmit),
    .o_send         (o_send),
    .i_flit         (i_flit),
    .o_pkt_done     (o_pkt_done),
    .o_pkt_count    (o_pkt_count),
    .o_err_count    (o_err_count),
    .o_err_flags    (o_err_flags),
    .o_last_latency (o_last_latency),
    .o_max_latency  (o_max_latency)
  );

  always #5 clk = ~clk;

  // Bench's own notion of "cycles since reset", used to stamp tails.
  logic [15:0] m_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) m_cnt <= 16'd0;
    else       m_cnt <= m_cnt + 16'd1;
  end

  int n_run = 0;
  int n_fail = 0;

  // Expected statistics.
  logic [31:0] e_pkt;
  logic [15:0] e_err, e_last, e_max;
  logic [3:0]  e_flags;

  function automatic FLIT_t mk(input FLIT_TYPE_t t, input logic [7:0] x, input logic [7:0] y,
                               input logic [15:0] r);
    FLIT_t f;
    f.flit = {1'b1, t, x, y, r};
    return f;
  endfunction

  function automatic void m_zero();
    e_pkt = 0; e_err = 0; e_last = 0; e_max = 0; e_flags = 0;
  endfunction

  function automatic void m_err_inc();
    if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
  endfunction

  function automatic void m_good(input logic [15:0] lat);
    if (e_pkt != 32'hFFFF_FFFF) e_pkt = e_pkt + 32'd1;
    e_last = lat;
    if (lat > e_max) e_max = lat;
  endfunction

  function automatic void m_bad(input int idx);
    m_err_inc();
    e_flags[idx] = 1'b1;
  endfunction

  function automatic void m_stray();
    m_err_inc();
    e_flags[CHK_ERR_STRAY] = 1'b1;
  endfunction

  function automatic string got_s();
    return $sformatf("pkt=%0d err=%0d flags=%b last=%0d max=%0d", o_pkt_count, o_err_count,
                     o_err_flags, o_last_latency, o_max_latency);
  endfunction

  function automatic string exp_s();
    return $sformatf("pkt=%0d err=%0d flags=%b last=%0d max=%0d", e_pkt, e_err, e_flags,
                     e_last, e_max);
  endfunction

  task automatic put(input FLIT_t f);
    @(negedge clk);
    i_flit = f;
  endtask

  task automatic idle(input int n);
    repeat (n) put('0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_enable = 1'b1; i_clear = 1'b0; i_transmit = 1'b0; i_flit = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_zero();
  endtask

  // Raise the request now; report how many negedges passed before o_send was seen (-1 = never).
  task automatic req_grant(output int waited);
    i_transmit = 1'b1;
    waited = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_send) begin
        waited = k;
        break;
      end
    end
    i_transmit = 1'b0;
  endtask

  // Idle the flit bus until o_pkt_done; then step one more cycle so statistics are visible.
  task automatic wait_done(output int waited);
    waited = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      i_flit = '0;
      if (o_pkt_done) begin
        waited = k;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_run++;
    if ({o_send, o_pkt_done, o_pkt_count, o_err_count, o_err_flags, o_last_latency,
         o_max_latency} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got send=%b done=%b %s, want all zero", o_send, o_pkt_done,
               got_s());
    end
  endtask

  task automatic test_good();
    int w;
    bit hit = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (m_cnt == 16'd100) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_run++;
    if (!hit) begin
      n_fail++;
      $display("FAIL good_cnt100: got cnt=%0d, want 100", m_cnt);
    end
    req_grant(w);
    n_run++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL good_send_next: got wait=%0d, want 0", w);
    end
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    n_run++;
    if (o_send !== 1'b0) begin
      n_fail++;
      $display("FAIL good_send_single: got o_send=%b, want 0", o_send);
    end
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(TAIL_FLIT, 8'd0, 8'd0, 16'd90));
    wait_done(w);
    n_run++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL good_done: got wait=%0d, want 0", w);
    end
    m_good(16'd15);
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL good_stats: got %s, want %s", got_s(), exp_s());
    end
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    req_grant(w);
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(TAIL_FLIT, 8'd0, 8'd0, 16'hFFF0));
    wait_done(w);
    m_good(16'd21);
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL wrap_stats: got %s, want %s", got_s(), exp_s());
    end
  endtask

  task automatic test_seq();
    int w;
    req_grant(w);
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(TAIL_FLIT, 8'd0, 8'd0, 16'd0));
    wait_done(w);
    n_run++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL seq_abort: got wait=%0d, want 0", w);
    end
    m_bad(CHK_ERR_SEQ);
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL seq_stats: got %s, want %s", got_s(), exp_s());
    end
  endtask

  task automatic test_addr();
    int w;
    req_grant(w);
    n_run++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL addr_grant_after_seq: got wait=%0d, want 0", w);
    end
    put(mk(HEAD_FLIT, 8'd2, 8'd3, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(TAIL_FLIT, 8'd0, 8'd0, 16'd3));
    wait_done(w);
    m_bad(CHK_ERR_ADDR);
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL addr_stats: got %s, want %s", got_s(), exp_s());
    end
  endtask

  // Second HEAD aborts the packet, and a flit arriving during CHECK is stray on top.
  task automatic test_stray_check();
    int w;
    req_grant(w);
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    n_run++;
    if (o_pkt_done !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_check_done: got o_pkt_done=%b, want 1", o_pkt_done);
    end
    put('0);
    m_bad(CHK_ERR_SEQ);
    m_stray();
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL stray_check_stats: got %s, want %s", got_s(), exp_s());
    end
  endtask

  task automatic test_timeout();
    int w;
    int k_done = -1;
    do_reset();
    req_grant(w);
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    for (int k = 0; k < 80; k++) begin
      put('0);
      if (o_pkt_done) begin
        k_done = k;
        break;
      end
    end
    n_run++;
    if (k_done < 64 || k_done > 70) begin
      n_fail++;
      $display("FAIL timeout_done: got idle cycles=%0d, want 64..70", k_done);
    end
    put('0);
    m_bad(CHK_ERR_TIMEOUT);
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL timeout_stats: got %s, want %s", got_s(), exp_s());
    end
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(TAIL_FLIT, 8'd0, 8'd0, 16'd0));
    put('0);
    m_stray();
    m_stray();
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL timeout_stray_stats: got %s, want %s", got_s(), exp_s());
    end
  endtask

  task automatic test_control();
    int w;
    int sends = 0;
    i_enable = 1'b0;
    i_transmit = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (o_send) sends++;
    end
    n_run++;
    if (sends != 0) begin
      n_fail++;
      $display("FAIL ctrl_disabled_grant: got sends=%0d, want 0", sends);
    end
    i_enable = 1'b1;
    req_grant(w);
    n_run++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL ctrl_enable_grant: got wait=%0d, want 0", w);
    end
    // Disabling mid-packet must not stop it.
    i_enable = 1'b0;
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    @(negedge clk);
    i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, m_cnt - 16'd7);
    wait_done(w);
    m_good(16'd7);
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL ctrl_inflight_stats: got %s, want %s", got_s(), exp_s());
    end
    // Clear coinciding with CHECK wins over the packet's update.
    i_enable = 1'b1;
    req_grant(w);
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    @(negedge clk);
    i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, m_cnt - 16'd40);
    @(negedge clk);
    i_flit = '0;
    n_run++;
    if (o_pkt_done !== 1'b1) begin
      n_fail++;
      $display("FAIL ctrl_clear_in_check: got o_pkt_done=%b, want 1", o_pkt_done);
    end
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    m_zero();
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL ctrl_clear_stats: got %s, want %s", got_s(), exp_s());
    end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [15:0] lat;
    req_grant(w);
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    lat = 16'($urandom_range(1, 500));
    @(negedge clk);
    i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, m_cnt - lat);
    wait_done(w);
    m_good(lat);
    req_grant(w);
    put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
    put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
    #2 reset = 1'b1;
    #1;
    m_zero();
    n_run++;
    if ({o_send, o_pkt_done, o_pkt_count, o_err_count, o_err_flags, o_last_latency,
         o_max_latency} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got send=%b done=%b %s, want all zero", o_send,
               o_pkt_done, got_s());
    end
    @(negedge clk);
    reset = 1'b0;
    i_flit = mk(BODY_FLIT, 8'd0, 8'd0, 16'd0);
    put(mk(TAIL_FLIT, 8'd0, 8'd0, 16'd0));
    put('0);
    m_stray();
    m_stray();
    n_run++;
    if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
        {e_pkt, e_err, e_flags, e_last, e_max}) begin
      n_fail++;
      $display("FAIL reset_mid_stray: got %s, want %s", got_s(), exp_s());
    end
  endtask

  task automatic test_random();
    int w, mode, v, nb;
    logic [7:0]  x, y;
    logic [15:0] r, lat;
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 2);
      req_grant(w);
      n_run++;
      if (w !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_grant: got wait=%0d, want 0", i, w);
      end
      idle($urandom_range(0, 4));
      if (mode == 2) begin
        v = $urandom_range(0, 3);
        nb = $urandom_range(0, 2);
        case (v)
          0: begin
            put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
            for (int b = 0; b < nb % 2; b++) put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
            put(mk(TAIL_FLIT, 8'd0, 8'd0, 16'd0));
          end
          1: begin
            put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
            for (int b = 0; b < nb; b++) put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
            put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
          end
          2: put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
          default: begin
            put(mk(HEAD_FLIT, 8'd1, 8'd0, 16'd0));
            idle($urandom_range(0, 3));
            put(mk(NONE_FLIT, 8'd0, 8'd0, 16'd0));
          end
        endcase
        wait_done(w);
        m_bad(CHK_ERR_SEQ);
      end else begin
        x = 8'd1;
        y = 8'd0;
        if (mode == 1) begin
          x = 8'($urandom);
          y = 8'($urandom);
          if (x == 8'd1 && y == 8'd0) y = 8'd9;
        end
        put(mk(HEAD_FLIT, x, y, 16'd0));
        for (int b = 0; b < 2; b++) begin
          idle($urandom_range(0, 4));
          put(mk(BODY_FLIT, 8'd0, 8'd0, 16'd0));
        end
        idle($urandom_range(0, 4));
        r = 16'($urandom);
        @(negedge clk);
        i_flit = mk(TAIL_FLIT, 8'd0, 8'd0, r);
        lat = m_cnt - r;
        wait_done(w);
        if (mode == 1) m_bad(CHK_ERR_ADDR);
        else           m_good(lat);
      end
      n_run++;
      if ({o_pkt_count, o_err_count, o_err_flags, o_last_latency, o_max_latency} !==
          {e_pkt, e_err, e_flags, e_last, e_max}) begin
        n_fail++;
        $display("FAIL rand%0d_stats mode=%0d: got %s, want %s", i, mode, got_s(), exp_s());
      end
    end
  endtask

  initial begin
    m_zero();
    test_reset();
    test_good();
    test_wrap();
    test_seq();
    test_addr();
    test_stray_check();
    test_timeout();
    test_control();
    test_reset_mid();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
